// File: rtl/bin2bcd_seq_if.sv
// Handshake and result bundle between a requester and the bin2bcd_seq converter.
// The requester drives start/bin; the converter returns busy/done/bcd/overflow.
interface bin2bcd_seq_if #(
  parameter int BIN_W = 14
);
  logic             start;
  logic [BIN_W-1:0] bin;
  logic             busy;
  logic             done;
  logic [15:0]      bcd;
  logic             overflow;

  modport master (
    output start,
    output bin,
    input  busy,
    input  done,
    input  bcd,
    input  overflow
  );

  modport slave (
    input  start,
    input  bin,
    output busy,
    output done,
    output bcd,
    output overflow
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per cycle).
// Feeds the 4-digit display multiplexer, so bcd only changes when a
// conversion completes. Digits above thousands are dropped (value mod 10000).
// Optional build macro: BIN2BCD_SATURATE_EN -- when defined, inputs above
// 9999 load 16'h9999 instead of the wrapped value.
module bin2bcd_seq #(
  parameter int BIN_W = 14
) (
  input  logic          clk,
  input  logic          rst_n,
  bin2bcd_seq_if.slave  bus
);

  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [BIN_W-1:0] shift_q, shift_d;
  logic [15:0]      scratch_q, scratch_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             big_q, big_d;
  logic [15:0]      bcd_q, bcd_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  logic [15:0]      corr;

  // Add 3 to every scratch digit that is 5 or more, all digits in parallel.
  always_comb begin
    corr = scratch_q;
    for (int i = 0; i < 4; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        corr[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Next-state logic: capture in IDLE, shift BIN_W times, then publish.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    count_d   = count_q;
    big_d     = big_q;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          shift_d   = bus.bin;
          scratch_d = 16'h0000;
          count_d   = '0;
          big_d     = (32'(bus.bin) > 32'd9999);
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        scratch_d = {corr[14:0], shift_q[BIN_W-1]};
        shift_d   = shift_q << 1;
        count_d   = count_q + 1'b1;
        if (count_q == CNT_W'(BIN_W - 1)) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
`ifdef BIN2BCD_SATURATE_EN
        bcd_d = big_q ? 16'h9999 : scratch_q;
`else
        bcd_d = scratch_q;
`endif
        ovf_d   = big_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any conversion in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      scratch_q <= 16'h0000;
      count_q   <= '0;
      big_q     <= 1'b0;
      bcd_q     <= 16'h0000;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      count_q   <= count_d;
      big_q     <= big_d;
      bcd_q     <= bcd_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = done_q;
  assign bus.bcd      = bcd_q;
  assign bus.overflow = ovf_q;

endmodule
